// File: rtl/uart_fifo_bridge.sv
// Byte bridge between the UART Rx/Tx cores and the CPU debug unit:
// show-ahead Rx FIFO, Tx FIFO drained by a small transmit FSM.

module uart_fifo_bridge_fifo #(
  parameter int NB_DATA = 8,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_pop,
  output logic [NB_DATA-1:0] o_head,
  output logic               o_empty,
  output logic               o_full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (i_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_data;
  end

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign o_head  = mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

module uart_fifo_bridge #(
  parameter int NB_DATA         = 8,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_rd,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_tx_start,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_tx_done,
  output logic               o_rx_full,
  output logic               o_rx_overrun,
  output logic               o_tx_full,
  input  logic [NB_DATA-1:0] i_uart_rx_data,
  input  logic               i_uart_rx_valid,
  output logic [NB_DATA-1:0] o_uart_tx_data,
  output logic               o_uart_tx_start,
  input  logic               i_uart_tx_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } tx_state_e;

  tx_state_e          state_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               overrun_q;

  logic [NB_DATA-1:0] rx_head, tx_head;
  logic               rx_empty, rx_full, tx_empty, tx_full;
  logic               rx_push, rx_pop, rx_drop;
  logic               tx_push, tx_pop;

  // A pop frees the slot, so a push into a full FIFO in the same cycle is not a drop.
  assign rx_pop  = i_rd & ~rx_empty;
  assign rx_push = i_uart_rx_valid & (~rx_full | rx_pop);
  assign rx_drop = i_uart_rx_valid & rx_full & ~rx_pop;

  assign tx_push = i_wr & ~tx_full;
  assign tx_pop  = (state_q == ST_LOAD) & ~tx_empty;

  uart_fifo_bridge_fifo #(
    .NB_DATA (NB_DATA),
    .ADDR_W  (FIFO_ADDR_WIDTH)
  ) u_rx_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (rx_push),
    .i_data  (i_uart_rx_data),
    .i_pop   (rx_pop),
    .o_head  (rx_head),
    .o_empty (rx_empty),
    .o_full  (rx_full)
  );

  uart_fifo_bridge_fifo #(
    .NB_DATA (NB_DATA),
    .ADDR_W  (FIFO_ADDR_WIDTH)
  ) u_tx_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (tx_push),
    .i_data  (i_wdata),
    .i_pop   (tx_pop),
    .o_head  (tx_head),
    .o_empty (tx_empty),
    .o_full  (tx_full)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      overrun_q <= 1'b0;
    end else if (rx_drop) begin
      overrun_q <= 1'b1;
    end
  end

  // LOAD samples the Tx FIFO each time round, so bytes written mid-drain are picked up.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_tx_start) state_q <= ST_LOAD;
        ST_LOAD: begin
          if (tx_empty) begin
            state_q <= ST_DONE;
          end else begin
            tx_data_q <= tx_head;
            state_q   <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT:  if (i_uart_tx_done) state_q <= ST_LOAD;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_data       = rx_empty ? '0 : rx_head;
  assign o_rx_done       = ~rx_empty;
  assign o_rx_full       = rx_full;
  assign o_rx_overrun    = overrun_q;
  assign o_tx_full       = tx_full;
  assign o_uart_tx_data  = tx_data_q;
  assign o_uart_tx_start = (state_q == ST_START);
  assign o_tx_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed scenarios plus randomized
// traffic compared against queue-based models of both FIFOs and the drain.

module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;

  logic       clk;
  logic       i_rst;
  logic       i_rd;
  logic       i_wr;
  logic [7:0] i_wdata;
  logic       i_tx_start;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_tx_done;
  logic       o_rx_full;
  logic       o_rx_overrun;
  logic       o_tx_full;
  logic [7:0] i_uart_rx_data;
  logic       i_uart_rx_valid;
  logic [7:0] o_uart_tx_data;
  logic       o_uart_tx_start;
  logic       i_uart_tx_done;

  uart_fifo_bridge #(
    .NB_DATA         (8),
    .FIFO_ADDR_WIDTH (4)
  ) dut (
    .clk             (clk),
    .i_rst           (i_rst),
    .i_rd            (i_rd),
    .i_wr            (i_wr),
    .i_wdata         (i_wdata),
    .i_tx_start      (i_tx_start),
    .o_rx_data       (o_rx_data),
    .o_rx_done       (o_rx_done),
    .o_tx_done       (o_tx_done),
    .o_rx_full       (o_rx_full),
    .o_rx_overrun    (o_rx_overrun),
    .o_tx_full       (o_tx_full),
    .i_uart_rx_data  (i_uart_rx_data),
    .i_uart_rx_valid (i_uart_rx_valid),
    .o_uart_tx_data  (o_uart_tx_data),
    .o_uart_tx_start (o_uart_tx_start),
    .i_uart_tx_done  (i_uart_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [7:0] rxq[$];
  logic       ovr_model;
  logic [7:0] tx_model[$];

  logic [7:0] sent_q[$];
  int done_cnt, done_cyc, udone_cyc, first_start_cyc, start_cyc;

  // Inputs applied at cycle cyc are captured by the next edge; outputs are
  // then read 1 time unit later as the values of cycle cyc+1.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    rxq.delete();
    tx_model.delete();
    ovr_model = 1'b0;
  endtask

  task automatic rx_model_cycle(input logic v, input logic [7:0] d, input logic rd);
    int  sz;
    bit  pop_ok;
    sz = rxq.size();
    pop_ok = rd && (sz > 0);
    if (pop_ok) void'(rxq.pop_front());
    if (v && (sz < DEPTH || pop_ok)) rxq.push_back(d);
    if (v && sz == DEPTH && !pop_ok) ovr_model = 1'b1;
  endtask

  task automatic rx_cycle(input logic v, input logic [7:0] d, input logic rd);
    i_uart_rx_valid = v;
    i_uart_rx_data  = d;
    i_rd            = rd;
    rx_model_cycle(v, d, rd);
    step();
    i_uart_rx_valid = 1'b0;
    i_rd            = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    i_wr    = 1'b1;
    i_wdata = b;
    if (tx_model.size() < DEPTH) tx_model.push_back(b);
    step();
    i_wr = 1'b0;
  endtask

  // Issues i_tx_start, acts as the UART Tx core (done pulse `delay` cycles
  // after each start), then checks what was sent against tx_model.
  task automatic run_drain(input string name, input int delay, input int budget,
                           input bit wr_with_start, input logic [7:0] start_byte,
                           input bit wr_in_wait, input logic [7:0] wait_byte);
    int pending;
    bit injected;
    sent_q.delete();
    done_cnt = 0; done_cyc = -1; udone_cyc = -1; first_start_cyc = -1;
    pending = -1; injected = 0;
    start_cyc = cyc;
    i_tx_start = 1'b1;
    i_wr       = wr_with_start;
    i_wdata    = start_byte;
    if (wr_with_start && tx_model.size() < DEPTH) tx_model.push_back(start_byte);
    step();
    i_tx_start = 1'b0;
    i_wr       = 1'b0;
    for (int c = 0; c < budget; c++) begin
      i_uart_tx_done = 1'b0;
      i_wr           = 1'b0;
      if (pending > 0) pending--;
      if (pending == 0) begin
        i_uart_tx_done = 1'b1;
        udone_cyc      = cyc;
        pending        = -1;
      end
      if (o_uart_tx_start) begin
        sent_q.push_back(o_uart_tx_data);
        if (first_start_cyc < 0) first_start_cyc = cyc;
        pending = delay;
      end
      if (wr_in_wait && !injected && pending > 0 && pending < delay) begin
        i_wr     = 1'b1;
        i_wdata  = wait_byte;
        injected = 1;
        tx_model.push_back(wait_byte);
      end
      if (o_tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      step();
    end
    i_uart_tx_done = 1'b0;
    i_wr           = 1'b0;

    tests_run++;
    if (sent_q.size() !== tx_model.size()) begin
      tests_failed++;
      $display("FAIL %s start-pulse count: got %0d expected %0d", name, sent_q.size(), tx_model.size());
    end
    for (int i = 0; i < sent_q.size() && i < tx_model.size(); i++) begin
      tests_run++;
      if (sent_q[i] !== tx_model[i]) begin
        tests_failed++;
        $display("FAIL %s byte %0d: got %02h expected %02h", name, i, sent_q[i], tx_model[i]);
      end
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s o_tx_done pulses: got %0d expected 1", name, done_cnt);
    end
    tests_run++;
    if (tx_model.size() == 0) begin
      if (done_cyc !== start_cyc + 2) begin
        tests_failed++;
        $display("FAIL %s empty-drain done latency: got cycle %0d expected %0d", name, done_cyc, start_cyc + 2);
      end
    end else begin
      if (first_start_cyc !== start_cyc + 2 || done_cyc !== udone_cyc + 2) begin
        tests_failed++;
        $display("FAIL %s latency: first start %0d (exp %0d), done %0d (exp %0d)",
                 name, first_start_cyc, start_cyc + 2, done_cyc, udone_cyc + 2);
      end
    end
    tx_model.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    tests_run++;
    if ({o_rx_data, o_rx_done, o_tx_done, o_rx_full, o_rx_overrun, o_tx_full,
         o_uart_tx_data, o_uart_tx_start} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset outputs: got %06h expected 000000",
               {o_rx_data, o_rx_done, o_tx_done, o_rx_full, o_rx_overrun, o_tx_full,
                o_uart_tx_data, o_uart_tx_start});
    end
    rxq.delete(); tx_model.delete(); ovr_model = 1'b0;
  endtask

  task automatic test_rx_basic();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    do_reset();
    rx_cycle(1'b1, 8'h11, 1'b0);
    tests_run++;
    if (o_rx_done !== 1'b1 || o_rx_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL rx first-byte latency: done=%b data=%02h expected done=1 data=11", o_rx_done, o_rx_data);
    end
    rx_cycle(1'b1, 8'h22, 1'b0);
    rx_cycle(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (o_rx_data !== exp_seq[i] || o_rx_done !== 1'b1) begin
        tests_failed++;
        $display("FAIL rx basic head %0d: data=%02h done=%b expected %02h done=1", i, o_rx_data, o_rx_done, exp_seq[i]);
      end
      rx_cycle(1'b0, 8'h00, 1'b1);
    end
    tests_run++;
    if (o_rx_done !== 1'b0 || o_rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL rx basic empty: done=%b data=%02h expected done=0 data=00", o_rx_done, o_rx_data);
    end
  endtask

  task automatic test_rx_overrun();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rx_cycle(1'b1, 8'(i * 7 + 3), 1'b0);
      if (i == DEPTH - 2) begin
        tests_run++;
        if (o_rx_full !== 1'b0) begin
          tests_failed++;
          $display("FAIL rx full after 15: got %b expected 0", o_rx_full);
        end
      end
    end
    tests_run++;
    if (o_rx_full !== 1'b1 || o_rx_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx full after 16: full=%b ovr=%b expected full=1 ovr=0", o_rx_full, o_rx_overrun);
    end
    rx_cycle(1'b1, 8'hC3, 1'b1);
    tests_run++;
    if (o_rx_full !== 1'b1 || o_rx_overrun !== 1'b0 || o_rx_data !== rxq[0]) begin
      tests_failed++;
      $display("FAIL rx push+pop while full: full=%b ovr=%b data=%02h expected full=1 ovr=0 data=%02h",
               o_rx_full, o_rx_overrun, o_rx_data, rxq[0]);
    end
    rx_cycle(1'b1, 8'hEE, 1'b0);
    tests_run++;
    if (o_rx_full !== 1'b1 || o_rx_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx overrun on 17th: full=%b ovr=%b expected full=1 ovr=1", o_rx_full, o_rx_overrun);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (o_rx_data !== rxq[0]) begin
        tests_failed++;
        $display("FAIL rx overrun drain %0d: got %02h expected %02h", i, o_rx_data, rxq[0]);
      end
      rx_cycle(1'b0, 8'h00, 1'b1);
    end
    tests_run++;
    if (o_rx_done !== 1'b0 || o_rx_overrun !== 1'b1 || o_rx_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx after drain: done=%b ovr=%b full=%b expected done=0 ovr=1 full=0",
               o_rx_done, o_rx_overrun, o_rx_full);
    end
  endtask

  task automatic test_rx_random();
    logic       v, rd;
    logic [7:0] d, exp_data;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // First half leans towards filling, second half towards draining.
      v  = (c < 200) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 30);
      rd = (c < 200) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 70);
      d  = 8'($urandom);
      rx_cycle(v, d, rd);
      exp_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
      tests_run++;
      if ({o_rx_data, o_rx_done, o_rx_full, o_rx_overrun} !==
          {exp_data, rxq.size() > 0, rxq.size() == DEPTH, ovr_model}) begin
        tests_failed++;
        $display("FAIL rx random cycle %0d: data=%02h done=%b full=%b ovr=%b expected data=%02h done=%b full=%b ovr=%b",
                 c, o_rx_data, o_rx_done, o_rx_full, o_rx_overrun,
                 exp_data, rxq.size() > 0, rxq.size() == DEPTH, ovr_model);
      end
    end
  endtask

  task automatic test_tx_drain();
    do_reset();
    push_tx(8'hA5);
    push_tx(8'h5A);
    run_drain("tx drain", 10, 60, 1'b0, 8'h00, 1'b0, 8'h00);
    tests_run++;
    if (o_uart_tx_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL tx data hold: got %02h expected 5a", o_uart_tx_data);
    end
  endtask

  task automatic test_tx_edges();
    do_reset();
    run_drain("tx wr with start", 10, 40, 1'b1, 8'h77, 1'b0, 8'h00);
    run_drain("tx empty drain", 10, 20, 1'b0, 8'h00, 1'b0, 8'h00);
    push_tx(8'h01);
    run_drain("tx wr in wait", 10, 60, 1'b0, 8'h00, 1'b1, 8'h02);
  endtask

  task automatic test_tx_full();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_tx(8'($urandom));
      if (i == DEPTH - 2 || i == DEPTH - 1) begin
        tests_run++;
        if (o_tx_full !== (i == DEPTH - 1)) begin
          tests_failed++;
          $display("FAIL tx full after %0d pushes: got %b expected %b", i + 1, o_tx_full, i == DEPTH - 1);
        end
      end
    end
    run_drain("tx full drain", 2, 120, 1'b0, 8'h00, 1'b0, 8'h00);
    tests_run++;
    if (o_tx_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx full after drain: got %b expected 0", o_tx_full);
    end
  endtask

  task automatic test_tx_random();
    int n, delay;
    bit inj;
    for (int it = 0; it < 5; it++) begin
      n     = $urandom_range(0, 6);
      delay = $urandom_range(1, 6);
      inj   = (n > 0) && (delay >= 2) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) push_tx(8'($urandom));
      run_drain("tx random", delay, 120, 1'b0, 8'h00, inj, 8'($urandom));
    end
  endtask

  task automatic test_reset_mid_drain();
    int budget;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) rx_cycle(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) push_tx(8'(8'hB0 + i));
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    budget = 10;
    while (!o_uart_tx_start && budget > 0) begin
      step();
      budget--;
    end
    tests_run++;
    if (o_uart_tx_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset mid-drain: no start pulse seen within 10 cycles");
    end
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    tests_run++;
    if ({o_rx_data, o_rx_done, o_tx_done, o_rx_full, o_rx_overrun, o_tx_full,
         o_uart_tx_data, o_uart_tx_start} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset mid-drain outputs: got %06h expected 000000",
               {o_rx_data, o_rx_done, o_tx_done, o_rx_full, o_rx_overrun, o_tx_full,
                o_uart_tx_data, o_uart_tx_start});
    end
    rxq.delete(); tx_model.delete(); ovr_model = 1'b0;
    run_drain("drain after reset", 10, 20, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    i_rst           = 1'b1;
    i_rd            = 1'b0;
    i_wr            = 1'b0;
    i_wdata         = 8'h00;
    i_tx_start      = 1'b0;
    i_uart_rx_data  = 8'h00;
    i_uart_rx_valid = 1'b0;
    i_uart_tx_done  = 1'b0;
    ovr_model       = 1'b0;

    test_reset();
    test_rx_basic();
    test_rx_overrun();
    test_rx_random();
    test_tx_drain();
    test_tx_edges();
    test_tx_full();
    test_tx_random();
    test_reset_mid_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
